dsram_resp: RTL and testbench
=============================

# dsram_resp

Responder end of the MEM-stage data-RAM interface: accepts the single-beat read/write requests issued by the MEM stage (`ram_ren`/`ram_wen`, 64-bit addresses, data and 64-bit bit-mask) and returns read data after a fixed, parameterised latency. While a transaction is in flight it drives `axi_busy_o`, which the MEM stage uses to gate re-issue. It sits between the MEM stage and the data memory, standing in for the future AXI data port.

## Interface
- `DEPTH_LOG2`, 12: log2 of the number of 64-bit words stored (4096 words = 32 KiB).
- `BASE_ADDR`, 64'h8000_0000: byte address of word 0.
- `LATENCY`, 2: number of cycles `axi_busy_o` is held per transaction; legal range 1..15.
- `clk` input 1: clock, all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `ram_ren_i` input 1: read request.
- `ram_wen_i` input 1: write request.
- `ram_raddr_i` input 64: read byte address.
- `ram_waddr_i` input 64: write byte address.
- `ram_wdata_i` input 64: write data.
- `ram_wmask_i` input 64: per-bit write enable; bit=1 writes that bit.
- `ram_rdata_o` output 64: read data, valid when `done_o`=1, held until the next accepted read.
- `axi_busy_o` output 1: transaction in flight.
- `done_o` output 1: one-cycle completion pulse.
- `err_o` output 1: one-cycle pulse with `done_o` when the transaction addressed out of range (only with `DSRAM_RANGE_CHK_EN`).

## Operation
- Word index = (addr − `BASE_ADDR`) >> 3, low `DEPTH_LOG2` bits; addr[2:0] ignored.
- States: IDLE, BUSY, RESP.
- IDLE: on an edge with `ram_ren_i | ram_wen_i` = 1, latch both addresses, wdata, wmask, and the ren/wen flags; load the counter with `LATENCY`−1; go to BUSY.
- BUSY: `axi_busy_o`=1; decrement the counter; at 0, go to RESP. Request inputs are ignored.
- Entering RESP: a latched write commits `mem[w] <= (mem[w] & ~mask) | (wdata & mask)`. A latched read loads `ram_rdata_o` from `mem[r]`.
- Read and write in the same transaction to the same word: the read returns the post-write value (merged data).
- Read-only transaction: memory is unchanged. Write-only transaction: `ram_rdata_o` keeps its previous value.
- RESP: `done_o`=1 for one cycle and `axi_busy_o`=0. A request present in RESP is accepted exactly as in IDLE (back-to-back, returns to BUSY); otherwise go to IDLE.
- A mask of all zeros is a legal no-op write.

## Timing
- Request sampled at edge E0. `axi_busy_o` is high in cycles E0+1 .. E0+`LATENCY`. `done_o` and valid `ram_rdata_o` appear at cycle E0+`LATENCY`+1.
- Throughput: one transaction per `LATENCY`+1 cycles.
- Reset (`rst`=0, any time, including mid-transaction):
  - State → IDLE.
  - `ram_rdata_o`=0, `axi_busy_o`=0, `done_o`=0, `err_o`=0.
  - A pending write is discarded. Memory array contents are not reset.
- First edge after `rst` deasserts: requests are accepted normally.

## Configuration
- `DSRAM_RANGE_CHK_EN` defined:
  - An address is out of range if addr < `BASE_ADDR` or addr ≥ `BASE_ADDR` + 8·2^`DEPTH_LOG2`.
  - An out-of-range write is suppressed; an out-of-range read returns 0.
  - `err_o` pulses with `done_o` if either enabled access is out of range.
  - Timing is unchanged.
- Not defined: the index wraps modulo depth, every access proceeds, and `err_o` is tied 0.

## Test plan
- Reset then idle: `ram_rdata_o`=0, `axi_busy_o`=0, `done_o`=0 for 10 cycles with no requests.
- Full write then read (`LATENCY`=2):
  - Write 64'h1122_3344_5566_7788 with all-ones mask to 0x8000_0010 → busy for 2 cycles, done at E0+3.
  - Read 0x8000_0010 → `ram_rdata_o`=64'h1122_3344_5566_7788 at E0+3.
- Byte mask: write 64'hFF with mask 64'hFF to 0x8000_0010, then read → 64'h1122_3344_5566_77FF.
- Simultaneous read+write to the same word, wdata 64'hDEAD_BEEF, mask 64'hFFFF_FFFF, prior value 0 → read returns 64'h0000_0000_DEAD_BEEF. Request held high through RESP → a second transaction starts back-to-back.
- Reset asserted in BUSY during a write to 0x8000_0020 → outputs 0 immediately; a subsequent read of 0x8000_0020 returns the old value.
- With `DSRAM_RANGE_CHK_EN`: write to 0x7FFF_FFF8 → `err_o`=1 with `done_o`, no memory change. Read of 0x8000_8000 → `ram_rdata_o`=0, `err_o`=1. Without the macro, the same read aliases to word 0.

Source files
------------

// File: rtl/dsram_resp_if.sv
// dsram_resp_if: MEM-stage <-> data-RAM responder bus.
// master = MEM stage (issues requests), slave = responder (returns data/status).
interface dsram_resp_if;
  logic        ram_ren_i;
  logic        ram_wen_i;
  logic [63:0] ram_raddr_i;
  logic [63:0] ram_waddr_i;
  logic [63:0] ram_wdata_i;
  logic [63:0] ram_wmask_i;
  logic [63:0] ram_rdata_o;
  logic        axi_busy_o;
  logic        done_o;
  logic        err_o;

  modport master (
    output ram_ren_i, ram_wen_i, ram_raddr_i, ram_waddr_i, ram_wdata_i, ram_wmask_i,
    input  ram_rdata_o, axi_busy_o, done_o, err_o
  );

  modport slave (
    input  ram_ren_i, ram_wen_i, ram_raddr_i, ram_waddr_i, ram_wdata_i, ram_wmask_i,
    output ram_rdata_o, axi_busy_o, done_o, err_o
  );
endinterface

// File: rtl/dsram_resp.sv
// dsram_resp: fixed-latency single-beat responder for the MEM-stage data RAM.
// A request is latched in IDLE/RESP, held BUSY for LATENCY cycles, then the
// write is committed and the read captured on the edge entering RESP.
// Optional feature macro: DSRAM_RANGE_CHK_EN (out-of-range accesses are
// suppressed/zeroed and flagged on err_o). Without it the index wraps.
module dsram_resp #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input logic         clk,
  input logic         rst,
  dsram_resp_if.slave bus
);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
`ifdef DSRAM_RANGE_CHK_EN
  localparam logic [63:0] LIMIT_ADDR = BASE_ADDR + (64'd8 << DEPTH_LOG2);
`endif

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  logic [63:0] mem [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ren_q, ren_d, wen_q, wen_d;
  logic        rok_q, rok_d, wok_q, wok_d;
  logic        err_q, err_d;
  logic [63:0] rdata_q, rdata_d;
  idx_t        ridx_q, ridx_d, widx_q, widx_d;
  logic [63:0] wdata_q, wdata_d, wmask_q, wmask_d;

  logic        req;
  logic        rok_in, wok_in;
  logic        commit;
  logic [63:0] merged;

  // Byte address -> word index; addr[2:0] drops out with the shift.
  function automatic idx_t word_idx(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BASE_ADDR;
    return idx_t'(off >> 3);
  endfunction

  // Range qualification of the incoming addresses and the merged write word.
  always_comb begin
`ifdef DSRAM_RANGE_CHK_EN
    rok_in = (bus.ram_raddr_i >= BASE_ADDR) && (bus.ram_raddr_i < LIMIT_ADDR);
    wok_in = (bus.ram_waddr_i >= BASE_ADDR) && (bus.ram_waddr_i < LIMIT_ADDR);
`else
    rok_in = 1'b1;
    wok_in = 1'b1;
`endif
    req    = bus.ram_ren_i | bus.ram_wen_i;
    commit = (state_q == ST_BUSY) && (cnt_q == 4'd0);
    merged = (mem[widx_q] & ~wmask_q) | (wdata_q & wmask_q);
  end

  // Next-state logic: accept in IDLE/RESP, count down in BUSY, respond once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    rok_d   = rok_q;
    wok_d   = wok_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    ridx_d  = ridx_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (req) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_INIT;
          ren_d   = bus.ram_ren_i;
          wen_d   = bus.ram_wen_i;
          rok_d   = rok_in;
          wok_d   = wok_in;
          err_d   = (bus.ram_ren_i & ~rok_in) | (bus.ram_wen_i & ~wok_in);
          ridx_d  = word_idx(bus.ram_raddr_i);
          widx_d  = word_idx(bus.ram_waddr_i);
          wdata_d = bus.ram_wdata_i;
          wmask_d = bus.ram_wmask_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          // Same-word read+write returns the merged (post-write) word.
          if (ren_q) begin
            if (!rok_q)
              rdata_d = 64'd0;
            else if (wen_q && wok_q && (widx_q == ridx_q))
              rdata_d = merged;
            else
              rdata_d = mem[ridx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and read-data registers; reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      rok_q   <= 1'b0;
      wok_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      rok_q   <= rok_d;
      wok_q   <= wok_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Request payload registers; only meaningful while a transaction is live.
  always_ff @(posedge clk) begin
    ridx_q  <= ridx_d;
    widx_q  <= widx_d;
    wdata_q <= wdata_d;
    wmask_q <= wmask_d;
  end

  // Memory commit on the edge entering RESP; a reset at that edge drops it.
  always_ff @(posedge clk) begin
    if (rst && commit && wen_q && wok_q)
      mem[widx_q] <= merged;
  end

  assign bus.ram_rdata_o = rdata_q;
  assign bus.axi_busy_o  = (state_q == ST_BUSY);
  assign bus.done_o      = (state_q == ST_RESP);
`ifdef DSRAM_RANGE_CHK_EN
  assign bus.err_o       = (state_q == ST_RESP) & err_q;
`else
  assign bus.err_o       = 1'b0 & err_q;
`endif
endmodule

// File: tb/tb_dsram_resp.sv
// tb_dsram_resp: randomized + directed bench for dsram_resp with a
// word-addressed associative-array reference model.
module tb_dsram_resp;
  localparam int          LAT   = 2;
  localparam int          DL2   = 12;
  localparam int          DEPTH = 1 << DL2;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dsram_resp_if bus ();

  dsram_resp #(.DEPTH_LOG2(DL2), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: memory contents by word index, last read data.
  logic [63:0] mdl [int unsigned];
  logic [63:0] exp_rdata = 64'd0;

  function automatic int unsigned m_idx(input logic [63:0] a);
    return int'(((a - BASE) >> 3) % DEPTH);
  endfunction

  function automatic logic m_ok(input logic [63:0] a);
`ifdef DSRAM_RANGE_CHK_EN
    return (a >= BASE) && (a < BASE + 64'(DEPTH) * 8);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step(input logic ren, input logic wen, input logic [63:0] ra,
                            input logic [63:0] wa, input logic [63:0] wd,
                            input logic [63:0] wm, output logic exp_err);
    logic [63:0] old;
    if (wen && m_ok(wa)) begin
      old = mdl.exists(m_idx(wa)) ? mdl[m_idx(wa)] : 64'd0;
      mdl[m_idx(wa)] = (old & ~wm) | (wd & wm);
    end
    if (ren) exp_rdata = m_ok(ra) ? mdl[m_idx(ra)] : 64'd0;
    exp_err = (ren && !m_ok(ra)) || (wen && !m_ok(wa));
  endtask

  // Drives one request at a negedge (DUT in IDLE or RESP) and observes the
  // busy window and the response; returns at the negedge of the RESP cycle.
  task automatic run_txn(input logic ren, input logic wen, input logic [63:0] ra,
                         input logic [63:0] wa, input logic [63:0] wd, input logic [63:0] wm,
                         output int busy_n, output logic done_v, output logic err_v,
                         output logic [63:0] rd_v);
    bus.ram_ren_i   = ren;
    bus.ram_wen_i   = wen;
    bus.ram_raddr_i = ra;
    bus.ram_waddr_i = wa;
    bus.ram_wdata_i = wd;
    bus.ram_wmask_i = wm;
    @(posedge clk);
    #1;
    bus.ram_ren_i = 1'b0;
    bus.ram_wen_i = 1'b0;
    busy_n = 0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (bus.axi_busy_o === 1'b1 && bus.done_o === 1'b0) busy_n++;
    end
    @(negedge clk);
    done_v = (bus.done_o === 1'b1) && (bus.axi_busy_o === 1'b0);
    err_v  = bus.err_o;
    rd_v   = bus.ram_rdata_o;
  endtask

  task automatic test_reset;
    logic [66:0] obs;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (bus.ram_rdata_o !== 64'd0) $display("FAIL reset_rdata: got %h want 0", bus.ram_rdata_o);
    else pass_cnt++;
    total_cnt++;
    if ({bus.axi_busy_o, bus.done_o, bus.err_o} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {bus.axi_busy_o, bus.done_o, bus.err_o});
    else pass_cnt++;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs = {bus.ram_rdata_o, bus.axi_busy_o, bus.done_o, bus.err_o};
      total_cnt++;
      if (obs !== 67'd0) $display("FAIL idle_cycle%0d: got %h want 0", i, obs);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_read;
    int bn; logic dv, ev, xe; logic [63:0] rv;
    model_step(1'b0, 1'b1, 64'h0, 64'h8000_0010, 64'h1122_3344_5566_7788, '1, xe);
    run_txn(1'b0, 1'b1, 64'h0, 64'h8000_0010, 64'h1122_3344_5566_7788, '1, bn, dv, ev, rv);
    total_cnt++;
    if (bn != LAT || !dv) $display("FAIL wr_timing: busy %0d done %b want busy %0d done 1", bn, dv, LAT);
    else pass_cnt++;
    total_cnt++;
    if (rv !== exp_rdata) $display("FAIL wr_only_rdata_hold: got %h want %h", rv, exp_rdata);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.done_o, bus.axi_busy_o} !== 2'b00)
      $display("FAIL done_one_cycle: got %b want 00", {bus.done_o, bus.axi_busy_o});
    else pass_cnt++;
    model_step(1'b1, 1'b0, 64'h8000_0010, 64'h0, 64'h0, 64'h0, xe);
    run_txn(1'b1, 1'b0, 64'h8000_0010, 64'h0, 64'h0, 64'h0, bn, dv, ev, rv);
    total_cnt++;
    if (rv !== 64'h1122_3344_5566_7788 || rv !== exp_rdata || !dv || bn != LAT)
      $display("FAIL rd_full: got %h done %b busy %0d want 1122334455667788", rv, dv, bn);
    else pass_cnt++;
  endtask

  task automatic test_byte_mask;
    int bn; logic dv, ev, xe; logic [63:0] rv;
    model_step(1'b0, 1'b1, 64'h0, 64'h8000_0010, 64'hFF, 64'hFF, xe);
    run_txn(1'b0, 1'b1, 64'h0, 64'h8000_0010, 64'hFF, 64'hFF, bn, dv, ev, rv);
    model_step(1'b1, 1'b0, 64'h8000_0010, 64'h0, 64'h0, 64'h0, xe);
    run_txn(1'b1, 1'b0, 64'h8000_0010, 64'h0, 64'h0, 64'h0, bn, dv, ev, rv);
    total_cnt++;
    if (rv !== 64'h1122_3344_5566_77FF || rv !== exp_rdata)
      $display("FAIL byte_mask: got %h want 11223344556677ff", rv);
    else pass_cnt++;
    // All-zero mask leaves the word untouched.
    model_step(1'b1, 1'b1, 64'h8000_0010, 64'h8000_0013, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, xe);
    run_txn(1'b1, 1'b1, 64'h8000_0010, 64'h8000_0013, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, bn, dv, ev, rv);
    total_cnt++;
    if (rv !== exp_rdata) $display("FAIL zero_mask: got %h want %h", rv, exp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_rw_same_back_to_back;
    int bn; logic dv, ev, xe; logic [63:0] rv;
    model_step(1'b0, 1'b1, 64'h0, 64'h8000_0040, 64'h0, '1, xe);
    run_txn(1'b0, 1'b1, 64'h0, 64'h8000_0040, 64'h0, '1, bn, dv, ev, rv);
    model_step(1'b1, 1'b1, 64'h8000_0040, 64'h8000_0040, 64'hDEAD_BEEF, 64'hFFFF_FFFF, xe);
    run_txn(1'b1, 1'b1, 64'h8000_0040, 64'h8000_0040, 64'hDEAD_BEEF, 64'hFFFF_FFFF, bn, dv, ev, rv);
    total_cnt++;
    if (rv !== 64'h0000_0000_DEAD_BEEF || rv !== exp_rdata)
      $display("FAIL rw_same_word: got %h want 00000000deadbeef", rv);
    else pass_cnt++;
    // Still in RESP: issue the next request immediately.
    model_step(1'b1, 1'b1, 64'h8000_0040, 64'h8000_0044, 64'h1234_0000_0000_0000,
               64'hFFFF_0000_0000_0000, xe);
    run_txn(1'b1, 1'b1, 64'h8000_0040, 64'h8000_0044, 64'h1234_0000_0000_0000,
            64'hFFFF_0000_0000_0000, bn, dv, ev, rv);
    total_cnt++;
    if (bn != LAT || !dv) $display("FAIL back_to_back: busy %0d done %b want busy %0d done 1", bn, dv, LAT);
    else pass_cnt++;
    total_cnt++;
    if (rv !== 64'h1234_0000_DEAD_BEEF || rv !== exp_rdata)
      $display("FAIL back_to_back_data: got %h want 12340000deadbeef", rv);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_busy;
    int bn; logic dv, ev, xe; logic [63:0] rv;
    model_step(1'b1, 1'b1, 64'h8000_0020, 64'h8000_0020, 64'hA5A5_5A5A_0F0F_F0F0, '1, xe);
    run_txn(1'b1, 1'b1, 64'h8000_0020, 64'h8000_0020, 64'hA5A5_5A5A_0F0F_F0F0, '1, bn, dv, ev, rv);
    @(negedge clk);
    bus.ram_wen_i   = 1'b1;
    bus.ram_waddr_i = 64'h8000_0020;
    bus.ram_wdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
    bus.ram_wmask_i = '1;
    @(posedge clk);
    #1;
    bus.ram_wen_i = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.axi_busy_o !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", bus.axi_busy_o);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus.ram_rdata_o, bus.axi_busy_o, bus.done_o, bus.err_o} !== 67'd0)
      $display("FAIL rst_async: rdata %h busy %b done %b want all 0",
               bus.ram_rdata_o, bus.axi_busy_o, bus.done_o);
    else pass_cnt++;
    exp_rdata = 64'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_step(1'b1, 1'b0, 64'h8000_0020, 64'h0, 64'h0, 64'h0, xe);
    run_txn(1'b1, 1'b0, 64'h8000_0020, 64'h0, 64'h0, 64'h0, bn, dv, ev, rv);
    total_cnt++;
    if (rv !== 64'hA5A5_5A5A_0F0F_F0F0 || rv !== exp_rdata || bn != LAT)
      $display("FAIL rst_write_dropped: got %h busy %0d want a5a55a5a0f0ff0f0", rv, bn);
    else pass_cnt++;
  endtask

  task automatic test_range;
    int bn; logic dv, ev, xe; logic [63:0] rv;
    model_step(1'b0, 1'b1, 64'h0, 64'h8000_0000, 64'h0101_0202_0303_0404, '1, xe);
    run_txn(1'b0, 1'b1, 64'h0, 64'h8000_0000, 64'h0101_0202_0303_0404, '1, bn, dv, ev, rv);
    model_step(1'b0, 1'b1, 64'h0, 64'h8000_7FF8, 64'h7777_6666_5555_4444, '1, xe);
    run_txn(1'b0, 1'b1, 64'h0, 64'h8000_7FF8, 64'h7777_6666_5555_4444, '1, bn, dv, ev, rv);
    // Below-base write: suppressed with err, or aliased to the last word.
    model_step(1'b0, 1'b1, 64'h0, 64'h7FFF_FFF8, 64'hCAFE_F00D_CAFE_F00D, '1, xe);
    run_txn(1'b0, 1'b1, 64'h0, 64'h7FFF_FFF8, 64'hCAFE_F00D_CAFE_F00D, '1, bn, dv, ev, rv);
    total_cnt++;
    if (ev !== xe || !dv) $display("FAIL low_write_err: err %b done %b want err %b done 1", ev, dv, xe);
    else pass_cnt++;
    model_step(1'b1, 1'b0, 64'h8000_7FF8, 64'h0, 64'h0, 64'h0, xe);
    run_txn(1'b1, 1'b0, 64'h8000_7FF8, 64'h0, 64'h0, 64'h0, bn, dv, ev, rv);
    total_cnt++;
    if (rv !== exp_rdata) $display("FAIL last_word: got %h want %h", rv, exp_rdata);
    else pass_cnt++;
    // One past the top: zero with err, or aliased to word 0.
    model_step(1'b1, 1'b0, 64'h8000_8000, 64'h0, 64'h0, 64'h0, xe);
    run_txn(1'b1, 1'b0, 64'h8000_8000, 64'h0, 64'h0, 64'h0, bn, dv, ev, rv);
    total_cnt++;
    if (rv !== exp_rdata || ev !== xe)
      $display("FAIL high_read: got %h err %b want %h err %b", rv, ev, exp_rdata, xe);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [63:0] pool [6];
    logic [63:0] ra, wa, wd, wm, rv;
    logic ren, wen, dv, ev, xe;
    int bn, op;
    for (int i = 0; i < 6; i++) begin
      pool[i] = BASE + 64'($urandom_range(0, DEPTH - 1)) * 8;
      wd = {$urandom, $urandom};
      model_step(1'b0, 1'b1, 64'h0, pool[i], wd, '1, xe);
      run_txn(1'b0, 1'b1, 64'h0, pool[i], wd, '1, bn, dv, ev, rv);
    end
    for (int t = 0; t < 40; t++) begin
      op  = $urandom_range(1, 3);
      ren = op[0];
      wen = op[1];
      ra  = pool[$urandom_range(0, 5)] + 64'($urandom_range(0, 7));
      wa  = pool[$urandom_range(0, 5)] + 64'($urandom_range(0, 7));
      wd  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       wm = '1;
        1:       wm = 64'd0;
        default: wm = {$urandom, $urandom};
      endcase
      model_step(ren, wen, ra, wa, wd, wm, xe);
      run_txn(ren, wen, ra, wa, wd, wm, bn, dv, ev, rv);
      total_cnt++;
      if (bn != LAT || !dv || ev !== xe || rv !== exp_rdata)
        $display("FAIL rand%0d: op %0d busy %0d done %b err %b rdata %h want busy %0d err %b rdata %h",
                 t, op, bn, dv, ev, rv, LAT, xe, exp_rdata);
      else pass_cnt++;
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
  endtask

  initial begin
    bus.ram_ren_i   = 1'b0;
    bus.ram_wen_i   = 1'b0;
    bus.ram_raddr_i = 64'd0;
    bus.ram_waddr_i = 64'd0;
    bus.ram_wdata_i = 64'd0;
    bus.ram_wmask_i = 64'd0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_rw_same_back_to_back();
    test_reset_in_busy();
    test_range();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end
endmodule
